// File: rtl/cpu_defs.sv
// Shared CPU constants: datapath width, register address width, x0 index.
// Imported by the writeback arbiter and its round-robin picker.
package cpu_defs;

  localparam int XLEN = 32;
  localparam int RAW  = 5;

  localparam logic [RAW-1:0] REG_ZERO = 5'd0;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant on the first set req
// scanning ptr+1, ptr+2, ... modulo N. Ports: req, ptr in; gnt out.
module rr_pick
  import cpu_defs::*;
#(
  parameter int N  = 3,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: round-robin among NREQ writeback
// sources, registered RegWr/Rw/busW, x0 writes dropped, global wr_stall.
// Ports: clk, rst, wr_stall, req_valid/ready/rd/data, RegWr, Rw, busW,
// grant_id, wr_pending.
module rf_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int RAW  = 5,
  parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_stall,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*RAW-1:0]  req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic                 RegWr,
  output logic [RAW-1:0]       Rw,
  output logic [XLEN-1:0]      busW,
  output logic [GW-1:0]        grant_id,
  output logic                 wr_pending
);

  import cpu_defs::*;

  logic [GW-1:0]   ptr;
  logic [GW-1:0]   gidx;
  logic [NREQ-1:0] pick;
  logic [RAW-1:0]  rd_sel;
  logic [XLEN-1:0] data_sel;
  logic            any_gnt;

  rr_pick #(
    .N  (NREQ),
    .PW (GW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (pick)
  );

  assign req_ready  = wr_stall ? '0 : pick;
  assign any_gnt    = |req_ready;
  assign wr_pending = (|req_valid) && !any_gnt;

  always_comb begin
    gidx     = '0;
    rd_sel   = '0;
    data_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        gidx     = GW'(i);
        rd_sel   = req_rd[i*RAW +: RAW];
        data_sel = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // x0 grants still advance ptr/grant_id but leave Rw/busW untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= GW'(NREQ - 1);
      RegWr    <= 1'b0;
      Rw       <= '0;
      busW     <= '0;
      grant_id <= '0;
    end else begin
      RegWr <= 1'b0;
      if (any_gnt) begin
        ptr      <= gidx;
        grant_id <= gidx;
        if (rd_sel != RAW'(REG_ZERO)) begin
          RegWr <= 1'b1;
          Rw    <= rd_sel;
          busW  <= data_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter: directed scenarios plus random
// traffic compared against a behavioural round-robin/regfile model.
module tb_rf_wr_arbiter;

  localparam int N = 3;
  localparam int X = 32;
  localparam int R = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_stall;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*R-1:0] req_rd;
  logic [N*X-1:0] req_data;
  logic           RegWr;
  logic [R-1:0]   Rw;
  logic [X-1:0]   busW;
  logic [1:0]     grant_id;
  logic           wr_pending;

  rf_wr_arbiter #(.NREQ(N), .XLEN(X), .RAW(R)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_stall   (wr_stall),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rd     (req_rd),
    .req_data   (req_data),
    .RegWr      (RegWr),
    .Rw         (Rw),
    .busW       (busW),
    .grant_id   (grant_id),
    .wr_pending (wr_pending)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_rw;
  logic [31:0] m_bus;
  int          m_gid;
  logic [31:0] m_rf [32];
  logic [31:0] d_rf [32];
  logic [N-1:0] rdy_s;

  always @(posedge clk) if (RegWr) d_rf[Rw] <= busW;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int mdl_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set(input int i, input logic v, input logic [4:0] rd,
                     input logic [31:0] d);
    req_valid[i]       = v;
    req_rd[i*R +: R]   = rd;
    req_data[i*X +: X] = d;
  endtask

  task automatic step();
    int g;
    logic [4:0] rd;
    @(negedge clk);
    g = (wr_stall || rst) ? -1 : mdl_pick(req_valid, m_ptr);
    rdy_s = req_ready;
    if (!rst) begin
      chk("ready", {61'd0, req_ready}, (g < 0) ? 64'd0 : (64'd1 << g));
      chk("pending", {63'd0, wr_pending},
          {63'd0, (|req_valid) && (g < 0)});
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_ptr = N - 1; m_we = 0; m_rw = 0; m_bus = 0; m_gid = 0;
    end else if (g >= 0) begin
      m_ptr = g;
      m_gid = g;
      rd = req_rd[g*R +: R];
      if (rd == 0) m_we = 0;
      else begin
        m_we = 1;
        m_rw = rd;
        m_bus = req_data[g*X +: X];
        m_rf[rd] = m_bus;
      end
    end else m_we = 0;
    chk("RegWr", {63'd0, RegWr}, {63'd0, m_we});
    chk("Rw", {59'd0, Rw}, {59'd0, m_rw});
    chk("busW", {32'd0, busW}, {32'd0, m_bus});
    chk("grant_id", {62'd0, grant_id}, 64'(m_gid));
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) set(i, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_rst();
    clr();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0]  prw;
    logic [31:0] pbus;
    logic        was_rst;
    rst = 1'b1; wr_stall = 1'b0;
    req_valid = '0; req_rd = '0; req_data = '0;
    for (int i = 0; i < 32; i++) begin m_rf[i] = 0; d_rf[i] = 0; end
    step();
    step();
    chk("rst_RegWr", {63'd0, RegWr}, 64'd0);
    chk("rst_busW", {32'd0, busW}, 64'd0);
    chk("rst_gid", {62'd0, grant_id}, 64'd0);
    rst = 1'b0;

    set(1, 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    chk("t1_ready", {61'd0, rdy_s}, 64'b010);
    chk("t1_we", {63'd0, RegWr}, 64'd1);
    chk("t1_rw", {59'd0, Rw}, 64'd5);
    chk("t1_bus", {32'd0, busW}, 64'hDEADBEEF);
    chk("t1_gid", {62'd0, grant_id}, 64'd1);
    clr();
    step();
    chk("t1_we_off", {63'd0, RegWr}, 64'd0);

    do_rst();
    for (int i = 0; i < N; i++) set(i, 1'b1, 5'(i + 1), 32'(100 + i));
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t2_order", {61'd0, rdy_s}, 64'd1 << (k % 3));
      chk("t2_we", {63'd0, RegWr}, 64'd1);
      chk("t2_bus", {32'd0, busW}, 64'(100 + k % 3));
    end

    do_rst();
    set(1, 1'b1, 5'd4, 32'h44);
    step();
    clr();
    prw = Rw; pbus = busW;
    set(0, 1'b1, 5'd0, 32'h1234);
    step();
    chk("t3_ready", {61'd0, rdy_s}, 64'b001);
    chk("t3_we", {63'd0, RegWr}, 64'd0);
    chk("t3_rw_hold", {59'd0, Rw}, {59'd0, prw});
    chk("t3_bus_hold", {32'd0, busW}, {32'd0, pbus});
    set(0, 1'b1, 5'd3, 32'h33);
    set(1, 1'b1, 5'd4, 32'h55);
    step();
    chk("t3_next", {61'd0, rdy_s}, 64'b010);
    clr();
    step();

    do_rst();
    set(0, 1'b1, 5'd10, 32'h10);
    set(2, 1'b1, 5'd12, 32'h12);
    wr_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_ready", {61'd0, rdy_s}, 64'd0);
      chk("t4_pend", {63'd0, wr_pending}, 64'd1);
      chk("t4_we", {63'd0, RegWr}, 64'd0);
    end
    wr_stall = 1'b0;
    step();
    chk("t4_first", {61'd0, rdy_s}, 64'b001);
    set(0, 1'b0, 5'd0, 32'd0);
    step();
    chk("t4_second", {61'd0, rdy_s}, 64'b100);
    clr();
    step();

    do_rst();
    set(0, 1'b1, 5'd7, 32'hA);
    set(2, 1'b1, 5'd7, 32'hB);
    step();
    chk("t5_a", {32'd0, busW}, 64'hA);
    set(0, 1'b0, 5'd0, 32'd0);
    step();
    chk("t5_b", {32'd0, busW}, 64'hB);
    chk("t5_we", {63'd0, RegWr}, 64'd1);
    clr();
    step();
    step();
    chk("t5_x7", {32'd0, d_rf[7]}, 64'hB);

    do_rst();
    set(0, 1'b1, 5'd9, 32'h99);
    step();
    chk("t6_we", {63'd0, RegWr}, 64'd1);
    do_rst();
    chk("t6_rst_we", {63'd0, RegWr}, 64'd0);
    set(1, 1'b1, 5'd1, 32'h1);
    set(2, 1'b1, 5'd2, 32'h2);
    step();
    chk("t6_first", {61'd0, rdy_s}, 64'b010);
    clr();

    for (int c = 0; c < 400; c++) begin
      was_rst = rst;
      for (int i = 0; i < N; i++) begin
        if ((rdy_s[i] && req_valid[i] && !was_rst) || !req_valid[i])
          set(i, ($urandom % 3) != 0,
              (($urandom % 5) == 0) ? 5'd0 : 5'($urandom),
              $urandom);
      end
      wr_stall = ($urandom % 5) == 0;
      rst      = ($urandom % 40) == 0;
      step();
    end
    rst = 1'b0;
    wr_stall = 1'b0;
    clr();
    step();
    step();
    for (int r = 1; r < 32; r++)
      chk("rf_final", {32'd0, d_rf[r]}, {32'd0, m_rf[r]});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Shares the single register-file write port (RegWr/Rw/busW into the decode-stage regfile) among NREQ writeback sources, e.g. ALU writeback, load unit and multi-cycle mul/div.
- Grants at most one source per cycle using round-robin arbitration with a valid/ready handshake.
- Registers the winning write so the regfile sees a clean one-cycle write pulse.
- Suppresses writes to x0 and supports a global stall.

Parameters:
- NREQ, 3, number of write requesters (2..8).
- XLEN, 32, data width.
- RAW, 5, register address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- wr_stall  in  1  when high, no grant is issued this cycle.
- req_valid  in  NREQ  per-source write request.
- req_ready  out  NREQ  per-source grant; one-hot or zero; combinational.
- req_rd  in  NREQ*RAW  destination register; source i occupies bits [i*RAW +: RAW].
- req_data  in  NREQ*XLEN  write data; source i occupies bits [i*XLEN +: XLEN].
- RegWr  out  1  registered write enable to the regfile.
- Rw  out  RAW  registered destination register.
- busW  out  XLEN  registered write data.
- grant_id  out  clog2(NREQ)  index of the last accepted source (registered).
- wr_pending  out  1  high when any req_valid is high and was not granted this cycle (combinational).

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: RegWr=0, Rw=0, busW=0, grant_id=0, round-robin pointer ptr=NREQ-1, so source 0 has top priority first.
- Handshake: a transfer occurs on a cycle where req_valid[i] && req_ready[i]. A source holds valid, rd and data stable until accepted. The arbiter never deasserts ready against a valid that it granted in the same cycle.
- Grant: if wr_stall=0 and any valid is set, req_ready is one-hot on the first valid index found scanning ptr+1, ptr+2, ... modulo NREQ. If wr_stall=1 or no valid is set, req_ready=0.
- Pointer: on a grant, ptr <= granted index at the next edge. With no grant, ptr holds.
- Latency: a write accepted at edge T appears on RegWr/Rw/busW for exactly the cycle following T, one cycle of latency. RegWr=1 lasts exactly one cycle per accepted write unless another write is accepted in the next cycle, giving back-to-back pulses.
- No grant in a cycle: RegWr <= 0; Rw and busW hold their previous values.
- x0: a request with rd=0 is accepted normally (ready asserted, ptr advances, grant_id updates). RegWr <= 0 the next cycle; Rw and busW hold.
- Fairness: with all NREQ sources continuously valid, each source is granted exactly once per NREQ consecutive cycles. Worst-case wait is NREQ-1 grant cycles plus any stall cycles.
- Same-rd collisions: two sources targeting the same rd are serialized by arbitration order. The later grant wins in the regfile. The arbiter does no ordering beyond round-robin; program order is the issue logic's responsibility.
- wr_stall mid-stream: with wr_stall high, RegWr goes 0 on the next edge. ptr and grant_id hold. Requests stay pending.
- Reset mid-operation: pending (unaccepted) requests are not recorded. An output write registered before the reset edge is cleared; rst has priority over every update.
- wr_pending = |req_valid && !(|req_ready).

Decomposition:
- Shared package (cpu_defs): XLEN, RAW and the REG_ZERO constant (5'd0). Reuse the existing package if present.
- Sub-module rr_pick: combinational round-robin picker. Inputs are the request vector and ptr; output is a one-hot grant. Also reusable for future arbiters, e.g. a memory port.
- Top level: pointer register, output write register and x0 suppression.

Test Plan:
- Reset, then source 1 alone valid with rd=5, data=0xDEADBEEF -> req_ready=3'b010 that cycle; next cycle RegWr=1, Rw=5, busW=0xDEADBEEF, grant_id=1; the cycle after, RegWr=0.
- All three sources valid continuously for 6 cycles from reset -> grant order 0,1,2,0,1,2; RegWr high for 6 consecutive cycles with matching Rw/busW.
- Source 0 valid with rd=0, data=0x1234 -> req_ready[0]=1; next cycle RegWr=0 and Rw/busW unchanged; ptr advanced, so a simultaneous next request from sources 0 and 1 grants 1.
- Sources 0 and 2 valid, wr_stall=1 for 3 cycles -> req_ready=0, RegWr=0, wr_pending=1 throughout; stall drops -> source 0 granted first, then source 2.
- Sources 0 and 2 both target rd=7 with data 0xA and 0xB -> two consecutive write pulses, 0xA then 0xB; a regfile read of x7 afterwards returns 0xB.
- Grant at edge T, then rst=1 at edge T+1 -> RegWr=0, ptr reset; after release, sources 1 and 2 valid -> source 1 granted first.
